qmax_reduce: RTL and testbench

- Reduction stage that consumes a single-level queue stream (value plus end-of-transaction flag) and emits one result per transaction.
- The result is the maximum value in the transaction and the index of its first occurrence.
- Sits downstream of the two-input max comparator. It collapses a stream of comparator outputs, or any raw value stream, into one per-transaction result.
- All connections use dti interfaces.

---
 rtl/qmax_reduce_if.sv | 14 +
 rtl/qmax_reduce.sv | 96 +++++++++
 tb/tb_qmax_reduce.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qmax_reduce_if.sv
// Valid/ready stream channel (dti) carrying a W-bit payload.
// producer/consumer and master/slave are the same two views under both names.
interface dti #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
  modport master   (output valid, output data, input ready);
  modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/qmax_reduce.sv
// Per-transaction max reduction: reports the largest value of each eot-terminated
// run and the index of its first occurrence.
module qmax_reduce #(
  parameter int DIN    = 16,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  din,
  dti.producer  dout
);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             first;
  logic [DIN-1:0]   acc;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic [DIN-1:0]   value;
  logic             eot;
  logic             din_hs;
  logic             dout_hs;
  logic             wins;
  logic [CNT_W-1:0] cnt_inc;

  assign value   = din.data[DIN-1:0];
  assign eot     = din.data[DIN];
  assign din_hs  = din.valid && din.ready;
  assign dout_hs = dout.valid && dout.ready;

  // Strict greater-than so that ties keep the earlier element.
  always_comb begin
    wins = 1'b0;
    if (SIGNED) wins = $signed(value) > $signed(acc);
    else        wins = value > acc;
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // While a result is pending, an element may only enter alongside its acceptance.
  assign din.ready  = (state == ACCUM) ? 1'b1 : dout.ready;
  assign dout.valid = (state == OUTPUT);
  assign dout.data  = {idx, acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      first <= 1'b1;
      acc   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (din_hs) begin
            if (first) begin
              acc   <= value;
              idx   <= '0;
              cnt   <= CNT_ONE;
              first <= 1'b0;
            end else begin
              if (wins) begin
                acc <= value;
                idx <= cnt;
              end
              cnt <= cnt_inc;
            end
            if (eot) state <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (dout_hs) begin
            if (din_hs) begin
              acc   <= value;
              idx   <= '0;
              cnt   <= CNT_ONE;
              first <= 1'b0;
              state <= eot ? OUTPUT : ACCUM;
            end else begin
              first <= 1'b1;
              state <= ACCUM;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_qmax_reduce.sv
// Scoreboard bench for qmax_reduce: three instances (unsigned, signed, 2-bit counter)
// driven by directed transactions; a negedge monitor pops expected results.
module tb_qmax_reduce;

  typedef struct packed {
    logic [15:0] val;
    logic [7:0]  idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid [3];
  logic [16:0] in_data  [3];
  logic        in_ready [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic [23:0] out_data [3];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t exp_q2[$];

  int n_checks = 0;
  int n_pass   = 0;
  int stalls   = 0;

  dti #(.W(17)) in_u ();
  dti #(.W(24)) out_u ();
  dti #(.W(17)) in_s ();
  dti #(.W(24)) out_s ();
  dti #(.W(17)) in_c ();
  dti #(.W(18)) out_c ();

  qmax_reduce #(.DIN(16), .SIGNED(1'b0), .CNT_W(8)) u_u (.clk(clk), .rst(rst), .din(in_u), .dout(out_u));
  qmax_reduce #(.DIN(16), .SIGNED(1'b1), .CNT_W(8)) u_s (.clk(clk), .rst(rst), .din(in_s), .dout(out_s));
  qmax_reduce #(.DIN(16), .SIGNED(1'b0), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .din(in_c), .dout(out_c));

  assign in_u.valid = in_valid[0];
  assign in_u.data  = in_data[0];
  assign in_s.valid = in_valid[1];
  assign in_s.data  = in_data[1];
  assign in_c.valid = in_valid[2];
  assign in_c.data  = in_data[2];
  assign out_u.ready = out_ready[0];
  assign out_s.ready = out_ready[1];
  assign out_c.ready = out_ready[2];

  assign in_ready[0]  = in_u.ready;
  assign in_ready[1]  = in_s.ready;
  assign in_ready[2]  = in_c.ready;
  assign out_valid[0] = out_u.valid;
  assign out_valid[1] = out_s.valid;
  assign out_valid[2] = out_c.valid;
  assign out_data[0]  = out_u.data;
  assign out_data[1]  = out_s.data;
  assign out_data[2]  = {6'b0, out_c.data};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic push_exp(input int k, input logic [15:0] val, input logic [7:0] idx);
    exp_t e;
    e.val = val;
    e.idx = idx;
    case (k)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  function automatic int queue_len(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  // u_c reports only a 2-bit index, so its expected index is kept within that range.
  task automatic check_output(input int k);
    exp_t e;
    if (queue_len(k) == 0) begin
      n_checks++;
      $display("[TB] FAIL unexpected_result dut%0d: got 0x%0h, expected no result", k, out_data[k]);
      return;
    end
    case (k)
      0:       e = exp_q0.pop_front();
      1:       e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
    check($sformatf("result_val dut%0d", k), {16'b0, out_data[k][15:0]}, {16'b0, e.val});
    check($sformatf("result_idx dut%0d", k), {24'b0, out_data[k][23:16]}, {24'b0, e.idx});
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (!rst && out_valid[k] && out_ready[k]) check_output(k);
  end

  // Holds one element on din until it is accepted; returns just after the accepting edge.
  task automatic apply_stimulus(input int k, input logic [15:0] v, input logic eot);
    int   waits;
    logic hs;
    waits = 0;
    hs = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = {eot, v};
    while (!hs && waits < 50) begin
      @(negedge clk);
      hs = in_ready[k];
      @(posedge clk);
      #1;
      if (!hs) waits++;
    end
    if (!hs) begin
      n_checks++;
      $display("[TB] FAIL din_timeout dut%0d: got no handshake, expected one within 50 cycles", k);
    end
    stalls += waits;
  endtask

  task automatic go_idle(input int k);
    in_valid[k] = 1'b0;
    in_data[k]  = '0;
  endtask

  initial begin
    logic [15:0] vals[4];
    logic [15:0] mx;
    logic [7:0]  mi;
    int          len;
    int          drain;

    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_dout_valid dut%0d", k), {31'b0, out_valid[k]}, 32'd0);
      check($sformatf("reset_din_ready dut%0d", k), {31'b0, in_ready[k]}, 32'd1);
      check($sformatf("reset_dout_data dut%0d", k), {8'b0, out_data[k]}, 32'd0);
    end
    @(posedge clk);
    #1;

    $display("[TB] basic transaction with tie");
    push_exp(0, 16'd9, 8'd1);
    apply_stimulus(0, 16'd3, 1'b0);
    apply_stimulus(0, 16'd9, 1'b0);
    apply_stimulus(0, 16'd4, 1'b0);
    apply_stimulus(0, 16'd9, 1'b1);
    go_idle(0);
    check("latency_dout_valid", {31'b0, out_valid[0]}, 32'd1);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] signed vs unsigned compare");
    push_exp(1, 16'h0001, 8'd1);
    push_exp(0, 16'hFFFE, 8'd0);
    fork
      begin
        apply_stimulus(1, 16'hFFFE, 1'b0);
        apply_stimulus(1, 16'h0001, 1'b0);
        apply_stimulus(1, 16'h8000, 1'b1);
        go_idle(1);
      end
      begin
        apply_stimulus(0, 16'hFFFE, 1'b0);
        apply_stimulus(0, 16'h0001, 1'b0);
        apply_stimulus(0, 16'h8000, 1'b1);
        go_idle(0);
      end
    join
    push_exp(1, 16'h8000, 8'd0);
    apply_stimulus(1, 16'h8000, 1'b1);
    go_idle(1);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] counter saturation");
    push_exp(2, 16'd8, 8'd3);
    apply_stimulus(2, 16'd1, 1'b0);
    apply_stimulus(2, 16'd1, 1'b0);
    apply_stimulus(2, 16'd1, 1'b0);
    apply_stimulus(2, 16'd1, 1'b0);
    apply_stimulus(2, 16'd8, 1'b0);
    apply_stimulus(2, 16'd1, 1'b1);
    go_idle(2);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] back-to-back with backpressure");
    out_ready[0] = 1'b0;
    push_exp(0, 16'd5, 8'd0);
    push_exp(0, 16'd7, 8'd0);
    apply_stimulus(0, 16'd5, 1'b1);
    fork
      begin
        apply_stimulus(0, 16'd7, 1'b0);
        apply_stimulus(0, 16'd2, 1'b1);
        go_idle(0);
      end
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check($sformatf("hold_valid c%0d", c), {31'b0, out_valid[0]}, 32'd1);
          check($sformatf("hold_data c%0d", c), {8'b0, out_data[0]}, 32'd5);
          check($sformatf("hold_din_ready c%0d", c), {31'b0, in_ready[0]}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] full throughput random transactions");
    stalls = 0;
    for (int t = 0; t < 100; t++) begin
      len = ($urandom_range(0, 1) == 0) ? 1 : 4;
      for (int i = 0; i < len; i++) vals[i] = 16'($urandom_range(0, 65535));
      mx = vals[0];
      mi = 8'd0;
      for (int i = 1; i < len; i++)
        if (vals[i] > mx) begin
          mx = vals[i];
          mi = 8'(i);
        end
      push_exp(0, mx, mi);
      for (int i = 0; i < len; i++) apply_stimulus(0, vals[i], (i == len - 1));
    end
    go_idle(0);
    check("throughput_stalls", 32'(stalls), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset mid-transaction");
    apply_stimulus(0, 16'd6, 1'b0);
    apply_stimulus(0, 16'd2, 1'b0);
    go_idle(0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_during_valid", {31'b0, out_valid[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_valid", {31'b0, out_valid[0]}, 32'd0);
    @(posedge clk);
    #1;
    push_exp(0, 16'd4, 8'd0);
    apply_stimulus(0, 16'd4, 1'b1);
    go_idle(0);

    drain = 0;
    while ((queue_len(0) + queue_len(1) + queue_len(2)) != 0 && drain < 200) begin
      @(posedge clk);
      drain++;
    end
    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("queue_empty dut%0d", k), 32'(queue_len(k)), 32'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
